// File: rtl/sp_ram_bist.sv
// sp_ram_bist: March C- self-test initiator driving a single-port SRAM wrapper
module sp_ram_bist #(
   parameter int ADR_BIT = 6,
   parameter int DAT_BIT = 32,
   parameter int WEN_BIT = 1,
   parameter logic [DAT_BIT-1:0] PATTERN = 32'h5555_5555
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [ADR_BIT-1:0] fail_addr,
   output logic [2:0]         fail_elem,
   output logic [DAT_BIT-1:0] fail_data,
   output logic [WEN_BIT-1:0] CEN,
   output logic [WEN_BIT-1:0] WEN,
   output logic [ADR_BIT-1:0] addr,
   output logic [DAT_BIT-1:0] w_data,
   input  logic [DAT_BIT-1:0] r_data
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic [2:0] elem, n_elem, exp_elem;
   logic phase, n_phase, rd, n_rd, step, term, down, last, cmp_valid;
   logic [ADR_BIT-1:0] n_addr, exp_addr;
   logic [DAT_BIT-1:0] exp_data;
   // work out the access after the one on the RAM port now: E0/E5 are single-op, E1-E4 read then write
   always_comb begin
      rd = elem == 3'd5 || (elem != 3'd0 && !phase);
      step = elem == 3'd0 || elem == 3'd5 || phase;
      down = elem == 3'd3 || elem == 3'd4;
      term = down ? addr == '0 : addr == '1;
      last = elem == 3'd5 && term;
      n_elem = step && term ? elem + 3'd1 : elem;
      n_phase = !step;
      n_addr = !step ? addr : term ? {ADR_BIT{n_elem == 3'd3 || n_elem == 3'd4}} : down ? addr - 1'b1 : addr + 1'b1;
      n_rd = n_elem == 3'd5 || (n_elem != 3'd0 && !n_phase);
   end
   // sequencer, RAM port registers and one-cycle-delayed read compare
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         fail <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_data <= '0;
         CEN <= '1;
         WEN <= '1;
         addr <= '0;
         w_data <= '0;
         elem <= '0;
         phase <= 1'b0;
         cmp_valid <= 1'b0;
         exp_data <= '0;
         exp_addr <= '0;
         exp_elem <= '0;
      end else begin
         cmp_valid <= state == RUN && rd;
         exp_data <= elem == 3'd2 || elem == 3'd4 ? ~PATTERN : PATTERN;
         exp_addr <= addr;
         exp_elem <= elem;
         if (cmp_valid && r_data != exp_data) begin
            fail <= 1'b1;
            if (!fail) begin
               fail_addr <= exp_addr;
               fail_elem <= exp_elem;
               fail_data <= r_data;
            end
         end
         case (state)
            IDLE: if (start) begin
               state <= RUN;
               busy <= 1'b1;
               done <= 1'b0;
               fail <= 1'b0;
               fail_addr <= '0;
               fail_elem <= '0;
               fail_data <= '0;
               elem <= '0;
               phase <= 1'b0;
               CEN <= '0;
               WEN <= '0;
               addr <= '0;
               w_data <= PATTERN;
            end
            RUN: begin
               elem <= n_elem;
               phase <= n_phase;
               addr <= n_addr;
               CEN <= {WEN_BIT{last}};
               WEN <= {WEN_BIT{last || n_rd}};
               w_data <= last || n_rd ? '0 : n_elem == 3'd1 || n_elem == 3'd3 ? ~PATTERN : PATTERN;
               if (last) state <= DRAIN;
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
               done <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_sp_ram_bist.sv
// tb_sp_ram_bist: directed checks of the March C- BIST against a 64x32 RAM model with injectable stuck-at bits
module tb_sp_ram_bist;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int N = 64;
   localparam logic [DW-1:0] P = 32'h5555_5555;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic busy, done, fail;
   logic [AW-1:0] fail_addr, addr;
   logic [2:0] fail_elem;
   logic [DW-1:0] fail_data, w_data, r_data, ram_q, noise;
   logic [0:0] CEN, WEN;
   logic [DW-1:0] mem [N];
   logic [DW-1:0] sa0 [N];
   logic [DW-1:0] sa1 [N];
   logic ex_we [10*N];
   logic [AW-1:0] ex_addr [10*N];
   logic [DW-1:0] ex_data [10*N];
   int checks = 0, errors = 0;
   int nb, serr;

   always #5 clk = ~clk;

   sp_ram_bist dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
      .CEN(CEN), .WEN(WEN), .addr(addr), .w_data(w_data), .r_data(r_data)
   );

   // RAM model: stuck-at faults are applied to the stored word
   always @(posedge clk)
      if (CEN == 1'b0) begin
         if (WEN == 1'b0) mem[addr] <= (w_data | sa1[addr]) & ~sa0[addr];
         else ram_q <= mem[addr];
      end
   assign r_data = ram_q ^ noise;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_ops;
      int i = 0;
      for (int e = 0; e < 6; e++)
         for (int k = 0; k < N; k++) begin
            int a = (e == 3 || e == 4) ? N - 1 - k : k;
            if (e != 0) begin
               ex_we[i] = 1'b0; ex_addr[i] = AW'(a); ex_data[i] = '0; i++;
            end
            if (e != 5) begin
               ex_we[i] = 1'b1; ex_addr[i] = AW'(a); ex_data[i] = (e == 1 || e == 3) ? ~P : P; i++;
            end
         end
   endtask

   task automatic run(input int restart_at, input int rst_at, output int nbusy, output int seq_err);
      nbusy = 0;
      seq_err = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("accept_clear", {done, fail, fail_addr, fail_elem, fail_data}, '0);
      for (int c = 0; c < 2000 && busy === 1'b1; c++) begin
         if (nbusy < 10*N) begin
            if (CEN !== 1'b0 || WEN !== ~ex_we[nbusy] || addr !== ex_addr[nbusy] || w_data !== ex_data[nbusy]) seq_err++;
         end else if (CEN !== 1'b1 || WEN !== 1'b1 || w_data !== '0) seq_err++;
         nbusy++;
         if (nbusy == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_cen", CEN, 1'b1);
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_done", done, 1'b0);
            break;
         end
         if (nbusy == restart_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      noise = '0;
      ram_q = '0;
      for (int i = 0; i < N; i++) begin
         sa0[i] = '0; sa1[i] = '0; mem[i] = '0;
      end
      build_ops();
      repeat (3) @(negedge clk);
      chk("rst_cen_wen", {CEN, WEN}, 2'b11);
      chk("rst_addr_wdata", {addr, w_data}, '0);
      chk("rst_flags", {busy, done, fail}, 3'b000);
      chk("rst_fail_info", {fail_addr, fail_elem, fail_data}, '0);
      rst_n = 1'b1;
      // fault-free run
      run(0, 0, nb, serr);
      chk("clean_busy_cycles", nb, 641);
      chk("clean_sequence_errs", serr, 0);
      chk("clean_done_fail", {busy, done, fail}, 3'b010);
      // read data toggling in idle must not be compared
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); noise = $urandom;
      end
      @(negedge clk); noise = '0;
      chk("idle_noise_flags", {busy, done, fail}, 3'b010);
      // stuck-at-1 bit 0 at addr 5: "0" data already has bit 0 set, first caught reading "1" in E2
      sa1[5] = 32'h1;
      run(0, 0, nb, serr);
      chk("sa1_busy_cycles", nb, 641);
      chk("sa1_flags", {done, fail}, 2'b11);
      chk("sa1_fail_addr", fail_addr, 6'd5);
      chk("sa1_fail_elem", fail_elem, 3'd2);
      chk("sa1_fail_data", fail_data, 32'hAAAA_AAAB);
      // stuck-at-0 bit 0 at addrs 5 and 40: caught in E1 at 5, later fault at 40 not recorded
      sa1[5] = '0;
      sa0[5] = 32'h1;
      sa0[40] = 32'h1;
      run(0, 0, nb, serr);
      chk("sa0_flags", {done, fail}, 2'b11);
      chk("sa0_fail_addr", fail_addr, 6'd5);
      chk("sa0_fail_elem", fail_elem, 3'd1);
      chk("sa0_fail_data", fail_data, 32'h5555_5554);
      // faults removed, start re-pulsed at busy cycle 100 must be ignored
      sa0[5] = '0;
      sa0[40] = '0;
      run(100, 0, nb, serr);
      chk("restart_busy_cycles", nb, 641);
      chk("restart_sequence_errs", serr, 0);
      chk("restart_done_fail", {busy, done, fail}, 3'b010);
      chk("restart_fail_info", {fail_addr, fail_elem, fail_data}, '0);
      // reset mid-run, then a clean full run
      run(0, 300, nb, serr);
      chk("rst_mid_cycles", nb, 300);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_idle", {busy, done, fail, CEN, WEN}, 5'b00011);
      run(0, 0, nb, serr);
      chk("post_rst_busy_cycles", nb, 641);
      chk("post_rst_sequence_errs", serr, 0);
      chk("post_rst_done_fail", {busy, done, fail}, 3'b010);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
